simon_datapath: RTL and testbench

Sequence-storage and comparison datapath for the Simon game, sitting underneath the Simon controller FSM. It executes the controller's one-cycle command strobes: append a legal switch pattern, step the playback and repeat indices, and drive the LEDs. It returns the status flags the controller branches on.

---
 rtl/simon_datapath_if.sv | 38 +++
 rtl/simon_datapath.sv | 96 +++++++++
 tb/tb_simon_datapath.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/simon_datapath_if.sv
// Command/status bundle between the Simon controller (master) and its datapath (slave).
// The controller drives the pattern, command strobes and LED source select.
interface simon_datapath_if #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 64
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] pattern;
   logic             cmd_clear;
   logic             cmd_store;
   logic             cmd_play_start;
   logic             cmd_play_next;
   logic             cmd_rep_start;
   logic             cmd_rep_next;
   logic [1:0]       disp_sel;

   logic [WIDTH-1:0] leds;
   logic             legal;
   logic [AW:0]      seq_len;
   logic             empty;
   logic             full;
   logic             play_last;
   logic             rep_last;
   logic             rep_match;

   modport master (
      output pattern, cmd_clear, cmd_store, cmd_play_start, cmd_play_next,
             cmd_rep_start, cmd_rep_next, disp_sel,
      input  leds, legal, seq_len, empty, full, play_last, rep_last, rep_match
   );

   modport slave (
      input  pattern, cmd_clear, cmd_store, cmd_play_start, cmd_play_next,
             cmd_rep_start, cmd_rep_next, disp_sel,
      output leds, legal, seq_len, empty, full, play_last, rep_last, rep_match
   );
endinterface

// File: rtl/simon_datapath.sv
// Simon sequence store with independent playback and repeat indices, LED drive
// and the status flags the controller branches on.
module simon_datapath #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 64
) (
   input logic              clk,
   input logic              rst,
   simon_datapath_if.slave  bus
);
   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {
      DISP_LIVE = 2'd0,
      DISP_PLAY = 2'd1,
      DISP_OFF  = 2'd2,
      DISP_ON   = 2'd3
   } disp_e;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      seq_len;
   logic [AW:0]      len_m1;
   logic [AW-1:0]    play_idx;
   logic [AW-1:0]    rep_idx;
   logic [WIDTH-1:0] leds_q;
   logic [WIDTH-1:0] led_next;
   logic             legal;
   logic             empty;
   logic             full;
   logic             play_last;
   logic             rep_last;
   logic             do_store;

   assign legal     = $onehot(bus.pattern);
   assign empty     = (seq_len == '0);
   assign full      = (seq_len == (AW+1)'(DEPTH));
   assign len_m1    = seq_len - (AW+1)'(1);
   assign play_last = !empty && (play_idx == len_m1[AW-1:0]);
   assign rep_last  = !empty && (rep_idx == len_m1[AW-1:0]);
   assign do_store  = bus.cmd_store && legal && !full;

   assign bus.legal     = legal;
   assign bus.seq_len   = seq_len;
   assign bus.empty     = empty;
   assign bus.full      = full;
   assign bus.play_last = play_last;
   assign bus.rep_last  = rep_last;
   assign bus.rep_match = !empty && (bus.pattern == mem[rep_idx]);
   assign bus.leds      = leds_q;

   // NOTE: memory has no reset; seq_len bounds every read, so stale entries are unreachable.
   always_ff @(posedge clk) begin
      if (!rst && !bus.cmd_clear && do_store)
         mem[seq_len[AW-1:0]] <= bus.pattern;
   end

   // NOTE: every assignment here is non-blocking so all state updates see pre-edge values;
   // this is what makes the index logic use the pre-store seq_len.
   always_ff @(posedge clk) begin
      if (rst) begin
         seq_len  <= '0;
         play_idx <= '0;
         rep_idx  <= '0;
         leds_q   <= '0;
      end else begin
         if (bus.cmd_clear)
            seq_len <= '0;
         else if (do_store)
            seq_len <= seq_len + (AW+1)'(1);

         if (bus.cmd_clear || bus.cmd_play_start)
            play_idx <= '0;
         else if (bus.cmd_play_next && !empty)
            play_idx <= play_last ? '0 : play_idx + AW'(1);

         if (bus.cmd_clear || bus.cmd_rep_start)
            rep_idx <= '0;
         else if (bus.cmd_rep_next && !empty)
            rep_idx <= rep_last ? '0 : rep_idx + AW'(1);

         leds_q <= led_next;
      end
   end

   always_comb begin
      // NOTE: default first so no path through the case leaves led_next unassigned (no latch).
      led_next = '0;
      case (disp_e'(bus.disp_sel))
         DISP_LIVE: led_next = bus.pattern;
         DISP_PLAY: if (!empty) led_next = mem[play_idx];
         DISP_OFF:  led_next = '0;
         DISP_ON:   led_next = '1;
         default:   led_next = '0;
      endcase
   end
endmodule

// File: tb/tb_simon_datapath.sv
// Scoreboard bench for simon_datapath: a behavioural model predicts post-edge state,
// expectations are queued at drive time and compared when the DUT cycle completes.
module tb_simon_datapath;
   localparam int WIDTH = 4;
   localparam int DEPTH = 64;

   logic clk = 1'b0;
   logic rst;

   simon_datapath_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

   simon_datapath #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   typedef struct {
      string tag;
      int    due;
      int    len;
      int    leds;
      bit    play_last;
      bit    rep_last;
      bit    empty;
      bit    full;
   } exp_t;

   exp_t sb[$];
   int   cyc      = 0;
   int   n_checks = 0;
   int   n_fail   = 0;

   logic [WIDTH-1:0] m_mem [DEPTH];
   int               m_len  = 0;
   int               m_play = 0;
   int               m_rep  = 0;
   int               m_leds = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic bit is_onehot(input logic [WIDTH-1:0] p);
      int c = 0;
      for (int i = 0; i < WIDTH; i++) c += int'(p[i]);
      return c == 1;
   endfunction

   // Behavioural model of one clock edge, using the inputs currently driven.
   task automatic model_step();
      int np, nr, nleds;
      bit pl, rl;
      if (rst) begin
         m_len = 0; m_play = 0; m_rep = 0; m_leds = 0;
      end else begin
         case (bus.disp_sel)
            2'd0:    nleds = int'(bus.pattern);
            2'd1:    nleds = (m_len == 0) ? 0 : int'(m_mem[m_play]);
            2'd2:    nleds = 0;
            default: nleds = (1 << WIDTH) - 1;
         endcase
         pl = (m_len != 0) && (m_play == m_len - 1);
         rl = (m_len != 0) && (m_rep == m_len - 1);
         np = m_play;
         if (bus.cmd_play_start) np = 0;
         else if (bus.cmd_play_next && m_len != 0) np = pl ? 0 : m_play + 1;
         nr = m_rep;
         if (bus.cmd_rep_start) nr = 0;
         else if (bus.cmd_rep_next && m_len != 0) nr = rl ? 0 : m_rep + 1;
         if (bus.cmd_clear) begin
            m_len = 0; np = 0; nr = 0;
         end else if (bus.cmd_store && is_onehot(bus.pattern) && m_len < DEPTH) begin
            m_mem[m_len] = bus.pattern;
            m_len++;
         end
         m_play = np;
         m_rep  = nr;
         m_leds = nleds;
      end
   endtask

   task automatic comb_checks(input string tag);
      check({tag, "/legal"}, 32'(bus.legal), 32'(is_onehot(bus.pattern)));
      check({tag, "/rep_match"}, 32'(bus.rep_match),
            32'((m_len != 0) && (bus.pattern == m_mem[m_rep])));
   endtask

   // One clock with the currently driven inputs; strobes and rst are released afterwards.
   task automatic cycle(input string tag);
      exp_t e;
      model_step();
      e.tag       = tag;
      e.due       = cyc + 1;
      e.len       = m_len;
      e.leds      = m_leds;
      e.play_last = (m_len != 0) && (m_play == m_len - 1);
      e.rep_last  = (m_len != 0) && (m_rep == m_len - 1);
      e.empty     = (m_len == 0);
      e.full      = (m_len == DEPTH);
      sb.push_back(e);
      @(posedge clk);
      @(negedge clk);
      #1;
      comb_checks(tag);
      rst = 1'b0;
      bus.cmd_clear = 1'b0; bus.cmd_store = 1'b0;
      bus.cmd_play_start = 1'b0; bus.cmd_play_next = 1'b0;
      bus.cmd_rep_start = 1'b0; bus.cmd_rep_next = 1'b0;
   endtask

   task automatic probe(input string tag, input logic [WIDTH-1:0] pat);
      bus.pattern = pat;
      #1;
      comb_checks(tag);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            check({e.tag, "/seq_len"},   32'(bus.seq_len),   e.len);
            check({e.tag, "/leds"},      32'(bus.leds),      e.leds);
            check({e.tag, "/play_last"}, 32'(bus.play_last), 32'(e.play_last));
            check({e.tag, "/rep_last"},  32'(bus.rep_last),  32'(e.rep_last));
            check({e.tag, "/empty"},     32'(bus.empty),     32'(e.empty));
            check({e.tag, "/full"},      32'(bus.full),      32'(e.full));
         end
      end
   end

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: time limit reached before end of stimulus");
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      logic [WIDTH-1:0] seq3 [3];
      logic [WIDTH-1:0] first_pat;
      seq3[0] = 4'b0001; seq3[1] = 4'b0100; seq3[2] = 4'b1000;
      first_pat = '0;

      // Reset with every command asserted
      rst = 1'b1;
      bus.pattern = 4'b0001; bus.disp_sel = 2'd3;
      bus.cmd_clear = 1'b1; bus.cmd_store = 1'b1;
      bus.cmd_play_start = 1'b1; bus.cmd_play_next = 1'b1;
      bus.cmd_rep_start = 1'b1; bus.cmd_rep_next = 1'b1;
      cycle("reset");
      check("reset/seq_len", 32'(bus.seq_len), 32'd0);
      check("reset/empty", 32'(bus.empty), 32'd1);
      check("reset/leds", 32'(bus.leds), 32'd0);
      check("reset/play_last", 32'(bus.play_last), 32'd0);
      check("reset/rep_match", 32'(bus.rep_match), 32'd0);

      // Legality and store
      bus.disp_sel = 2'd0;
      probe("legal_0010", 4'b0010);
      check("legal_0010/lit", 32'(bus.legal), 32'd1);
      bus.cmd_store = 1'b1;
      cycle("store_0010");
      check("store_0010/len", 32'(bus.seq_len), 32'd1);
      probe("legal_0110", 4'b0110);
      check("legal_0110/lit", 32'(bus.legal), 32'd0);
      bus.cmd_store = 1'b1;
      cycle("store_0110");
      check("store_0110/len", 32'(bus.seq_len), 32'd1);
      probe("legal_0000", 4'b0000);
      check("legal_0000/lit", 32'(bus.legal), 32'd0);
      probe("legal_1111", 4'b1111);

      // Playback wrap over a three-entry sequence
      bus.cmd_clear = 1'b1;
      cycle("clear");
      for (int i = 0; i < 3; i++) begin
         bus.pattern = seq3[i];
         bus.cmd_store = 1'b1;
         cycle("store_seq");
      end
      bus.disp_sel = 2'd1;
      bus.cmd_play_start = 1'b1;
      cycle("play_start");
      cycle("play_show0");
      check("play_show0/leds", 32'(bus.leds), 32'h1);
      for (int i = 0; i < 3; i++) begin
         bus.cmd_play_next = 1'b1;
         cycle("play_next");
         if (i == 1) check("play_idx2/play_last", 32'(bus.play_last), 32'd1);
      end
      cycle("play_wrapped");
      check("play_wrapped/leds", 32'(bus.leds), 32'h1);

      // Repeat compare
      bus.cmd_rep_start = 1'b1;
      cycle("rep_start");
      probe("rep_0001", 4'b0001);
      check("rep_0001/lit", 32'(bus.rep_match), 32'd1);
      probe("rep_0010", 4'b0010);
      check("rep_0010/lit", 32'(bus.rep_match), 32'd0);
      for (int i = 0; i < 2; i++) begin
         bus.cmd_rep_next = 1'b1;
         cycle("rep_next");
      end
      check("rep_idx2/rep_last", 32'(bus.rep_last), 32'd1);
      probe("rep_1000", 4'b1000);
      check("rep_1000/lit", 32'(bus.rep_match), 32'd1);
      bus.cmd_play_next = 1'b1; bus.cmd_rep_next = 1'b1;
      cycle("both_next");

      // Priorities
      bus.pattern = 4'b0001;
      bus.cmd_clear = 1'b1; bus.cmd_store = 1'b1;
      cycle("clear_vs_store");
      check("clear_vs_store/len", 32'(bus.seq_len), 32'd0);
      bus.cmd_play_next = 1'b1;
      cycle("next_when_empty");
      bus.pattern = 4'b0010; bus.cmd_store = 1'b1;
      cycle("store_a");
      bus.pattern = 4'b0100; bus.cmd_store = 1'b1; bus.cmd_play_next = 1'b1;
      cycle("store_with_next");
      bus.cmd_play_start = 1'b1; bus.cmd_play_next = 1'b1;
      cycle("start_vs_next");
      cycle("start_vs_next_show");
      check("start_vs_next/leds", 32'(bus.leds), 32'h2);
      bus.cmd_play_next = 1'b1;
      cycle("play_before_rst");
      rst = 1'b1; bus.cmd_play_next = 1'b1; bus.cmd_store = 1'b1;
      cycle("rst_mid");
      check("rst_mid/seq_len", 32'(bus.seq_len), 32'd0);
      check("rst_mid/leds", 32'(bus.leds), 32'd0);
      check("rst_mid/empty", 32'(bus.empty), 32'd1);
      check("rst_mid/play_last", 32'(bus.play_last), 32'd0);
      check("rst_mid/rep_match", 32'(bus.rep_match), 32'd0);

      // Fill to DEPTH, then one more store must be ignored
      bus.disp_sel = 2'd0;
      for (int i = 0; i < DEPTH; i++) begin
         bus.pattern = WIDTH'(1 << $urandom_range(0, WIDTH - 1));
         if (i == 0) first_pat = bus.pattern;
         bus.cmd_store = 1'b1;
         cycle("fill");
      end
      check("fill/full", 32'(bus.full), 32'd1);
      check("fill/seq_len", 32'(bus.seq_len), 32'(DEPTH));
      bus.pattern = (first_pat == 4'b0001) ? 4'b0010 : 4'b0001;
      bus.cmd_store = 1'b1;
      cycle("store_when_full");
      check("store_when_full/seq_len", 32'(bus.seq_len), 32'(DEPTH));
      bus.disp_sel = 2'd1; bus.cmd_play_start = 1'b1;
      cycle("full_play_start");
      cycle("full_show0");
      check("full_show0/leds", 32'(bus.leds), 32'(first_pat));
      bus.cmd_rep_start = 1'b1;
      cycle("full_rep_start");
      for (int i = 0; i < DEPTH - 1; i++) begin
         bus.cmd_rep_next = 1'b1;
         cycle("full_rep_next");
      end
      check("full_rep_end/rep_last", 32'(bus.rep_last), 32'd1);

      repeat (3) @(negedge clk);
      #2;
      if (sb.size() != 0) check("scoreboard_drain", 32'(sb.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
